// File: rtl/tick_sched_pkg.sv
// Shared types and widths for the tick scheduler slice.
// Holds the config FSM encoding, channel-index width and default counter width.
package tick_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } cfg_state_t;

    localparam int CH_W      = 4;
    localparam int CNT_W_DEF = 26;

endpackage

// File: rtl/tick_scheduler_if.sv
// Divisor configuration port: valid/ready request plus error pulse back to the requester.
// The master drives the request fields; the slave (scheduler) returns ready and err.
interface tick_scheduler_if
    import tick_sched_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_err;

    modport master (output cfg_valid, cfg_ch, cfg_div, input cfg_ready, cfg_err);
    modport slave  (input cfg_valid, cfg_ch, cfg_div, output cfg_ready, cfg_err);
endinterface

// File: rtl/tick_channel.sv
// One tick channel: divisor register, wrap counter, registered tick and optional square wave.
// Latency: tick one cycle after the wrap edge; load restarts the count from 0. No backpressure.
// TICK_SCHED_SQUARE_EN builds the sq toggle flop; otherwise sq is tied low.
module tick_channel
    import tick_sched_pkg::*;
#(
    parameter int          CNT_W       = CNT_W_DEF,
    parameter int unsigned DEFAULT_DIV = 50_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             load,
    input  logic [CNT_W-1:0] load_div,
    output logic             wrap,
    output logic             div_zero,
    output logic             tick,
    output logic             sq
);
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;

    assign div_zero = (div == '0);
    assign wrap     = run && !div_zero && (cnt == div - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            div  <= CNT_W'(DEFAULT_DIV);
            tick <= 1'b0;
        end else begin
            // The old period's tick is still emitted when a load lands on a wrap.
            tick <= wrap;
            if (load) begin
                div <= load_div;
                cnt <= '0;
            end else if (run && !div_zero) begin
                cnt <= wrap ? '0 : cnt + CNT_W'(1);
            end
        end
    end

`ifdef TICK_SCHED_SQUARE_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sq <= 1'b0;
        end else if (wrap) begin
            sq <= ~sq;
        end
    end
`else
    assign sq = 1'b0;
`endif

endmodule

// File: rtl/tick_scheduler.sv
// Per-channel clock-enable tick generator with runtime divisors applied at the channel's next wrap.
// Latency: ticks registered; config accepted in one cycle, applied within D_old cycles.
// Backpressure: cfg_ready low while a request is pending. Macro TICK_SCHED_SQUARE_EN enables sq.
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int          N_CH        = 4,
    parameter int          CNT_W       = CNT_W_DEF,
    parameter int unsigned DEFAULT_DIV = 50_000_000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    tick_scheduler_if.slave cfg,
    output logic [N_CH-1:0] tick,
    output logic [N_CH-1:0] sq
);
    cfg_state_t       state, state_nxt;
    logic [CH_W-1:0]  pend_ch;
    logic [CNT_W-1:0] pend_div;
    logic             err_q;
    logic             cfg_ready_c;
    logic [N_CH-1:0]  wrap, div_zero, load;
    logic             ch_ok, tgt_wrap, tgt_zero, apply;

    assign ch_ok = ({1'b0, cfg.cfg_ch} < (CH_W+1)'(N_CH));

    always_comb begin
        tgt_wrap = 1'b0;
        tgt_zero = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (pend_ch == CH_W'(i)) begin
                tgt_wrap = wrap[i];
                tgt_zero = div_zero[i];
            end
        end
    end

    // A stopped or disabled target never wraps, so it takes the new divisor at once.
    assign apply = (state == PEND) && (tgt_wrap || tgt_zero || !run);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cfg.cfg_valid && ch_ok) state_nxt = PEND;
            PEND:    if (apply)                  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cfg_ready_c = (state == IDLE);
        load        = '0;
        for (int i = 0; i < N_CH; i++) begin
            load[i] = apply && (pend_ch == CH_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_ch  <= '0;
            pend_div <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= cfg_ready_c && cfg.cfg_valid && !ch_ok;
            if (cfg_ready_c && cfg.cfg_valid && ch_ok) begin
                pend_ch  <= cfg.cfg_ch;
                pend_div <= cfg.cfg_div;
            end
        end
    end

    assign cfg.cfg_ready = cfg_ready_c;
    assign cfg.cfg_err   = err_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        tick_channel #(
            .CNT_W      (CNT_W),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .run     (run),
            .load    (load[g]),
            .load_div(pend_div),
            .wrap    (wrap[g]),
            .div_zero(div_zero[g]),
            .tick    (tick[g]),
            .sq      (sq[g])
        );
    end

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

- Generates per-channel single-cycle clock-enable pulses (`tick`) from the board clock, so downstream logic runs at slow rates on one clock domain instead of using counter bits as derived clocks.
- Each channel has its own divisor, changed at runtime through a valid/ready configuration port.
- A divisor change takes effect only at the target channel's next wrap, so no tick period is ever truncated.
- Sits between the board clock input and every slow-rate consumer (displays, FSM steppers, blinkers).

## Interface
- `N_CH`, 4: number of tick channels (1..16).
- `CNT_W`, 26: divisor and counter width in bits.
- `DEFAULT_DIV`, 50_000_000: divisor loaded into every channel at reset (must fit in `CNT_W`).
- `clk`  in  1: board clock; all logic on its rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `run`  in  1: global enable; low freezes all counters.
- `cfg_valid`  in  1: configuration request.
- `cfg_ready`  out  1: configuration slot free.
- `cfg_ch`  in  4: target channel index.
- `cfg_div`  in  CNT_W: new divisor, unsigned.
- `cfg_err`  out  1: one-cycle pulse when a request names a channel ≥ `N_CH`.
- `tick`  out  N_CH: per-channel enable pulse, registered.
- `sq`  out  N_CH: per-channel square wave, registered (see Configuration).

## Operation
- **Reset** (`rst_n`=0 at a rising edge):
  - counters 0, `tick`=0, `sq`=0, `cfg_err`=0, `cfg_ready`=1;
  - every divisor = `DEFAULT_DIV`; pending slot empty; FSM in IDLE.
  - Reset mid-operation drops any pending request.
- **Divisor D semantics:**
  - D=0: channel disabled; counter held at 0; no ticks; `sq` holds.
  - D=1: tick every cycle while `run`=1.
  - D≥2: one tick every D cycles.
- **Per-channel edge update**, only when `run`=1 and D≠0:
  - counter == D−1: counter←0 and `tick[i]`←1; otherwise counter←counter+1 and `tick[i]`←0.
  - D−1 is computed in `CNT_W` bits.
  - When `run`=0: counters hold, `tick`←0.
- **Config FSM:**
  - IDLE: `cfg_ready`=1. On `cfg_valid`∧`cfg_ready`:
    - if `cfg_ch` < `N_CH`, latch {ch, div} into the pending slot and go to PEND;
    - otherwise pulse `cfg_err` the next cycle and stay in IDLE.
  - PEND: `cfg_ready`=0. Apply the pending divisor at the first edge where any of these holds for the target channel:
    - (a) it wraps;
    - (b) its current D=0;
    - (c) `run`=0.
  - On apply: divisor←new, counter←0, return to IDLE. `cfg_ready` is 1 in the following cycle.
- **Simultaneous wrap and apply:** the tick for the old period is still emitted; the next period uses the new D, counting from 0.
- **Writing D=0** disables the channel after its current period completes.
- **Writing D equal to the current divisor** is legal; it has no visible effect beyond the normal wrap.

## Timing
- With `run` held at 1 from the first edge after reset release, channel i's first `tick` is high in the cycle after the D-th edge.
- After that, `tick` is high for exactly 1 cycle out of every D.
- Config acceptance to apply: at most D_old cycles. Apply to the first tick at the new rate: D_new cycles.
- `cfg_err` is high for exactly one cycle, the cycle after acceptance.
- All outputs are registered. There are no combinational paths from inputs to outputs, except `cfg_ready`, which is a function of FSM state only.

## Configuration
- Macro: `TICK_SCHED_SQUARE_EN`.
- Defined: `sq[i]` toggles on every edge that sets `tick[i]`, giving a 50% duty square wave of period 2·D, for LEDs and buzzers.
- Undefined: the `sq` port remains and is driven constant 0. The toggle flops are not built.

## Structure
- Package `tick_sched_pkg` holds:
  - the FSM state enum (IDLE, PEND);
  - `CH_W` = 4 (width of `cfg_ch`);
  - the default `CNT_W`.
- Sub-module `tick_channel` contains one counter, its divisor register, the wrap compare, the `tick` flop and the optional `sq` flop.
  - It takes a `load` strobe plus the new divisor.
  - It exports a `wrap` signal used by the FSM for apply condition (a).
- The top level instantiates `N_CH` `tick_channel` copies plus the config FSM and the pending slot.

## Test plan
Bench uses `DEFAULT_DIV`=4 and `N_CH`=4.
- **Reset then run=1:** every `tick` high at cycles 4, 8, 12…; `sq` toggles at those same cycles (macro defined).
- **run low for 3 cycles at counter=2:** no ticks during the pause; after `run` returns, the next tick arrives 2 cycles later.
- **Write ch1 div=2 at counter=1:**
  - `cfg_ready` is 0 for 2 cycles;
  - ch1 ticks at the old wrap, then every 2 cycles;
  - the other channels are unchanged.
- **Write ch2 div=0, then ch2 div=3:** ch2 stops after its current period; the second write applies immediately (D=0 case), and ticks resume every 3 cycles.
- **cfg_ch=7:** `cfg_err` pulses once; no channel is affected; `cfg_ready` stays 1.
- **rst_n low while in PEND:** the pending write is discarded; all divisors return to 4 and `cfg_ready`=1.
